// File: rtl/serial_rx_8x.sv
// serial_rx_8x: 8N1 UART receiver driven by an 8x-oversampling clock enable.
// Synchronizes rxd, qualifies the start bit and samples 8 data bits LSB-first.
// It then checks the stop bit and hands each byte out through a valid/ack
// holding register.
//
// Optional build macro: SERIAL_RX_PARITY_EN
//   When it is defined, the frame is 8E1. A parity error is reported on
//   rx_framing_err.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   baud8          in   one-cycle strobe at 8x the baud rate
//   rxd            in   raw serial pin (asynchronous, idle high)
//   rx_data        out  last received byte, stable while rx_valid=1
//   rx_valid       out  byte available, held until rx_ack
//   rx_ack         in   consumer acknowledge
//   rx_framing_err out  one-cycle pulse: bad stop bit (or bad parity)
//   rx_overrun     out  one-cycle pulse: byte dropped because rx_valid was held
module serial_rx_8x #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned START_CHECK = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud8,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_framing_err,
  output logic       rx_overrun
);

  localparam int unsigned PH_W     = 3;
  localparam logic [PH_W-1:0] CHECK_PH = PH_W'(START_CHECK);
  localparam logic [PH_W-1:0] LAST_PH  = PH_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [PH_W-1:0]        r_phase;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shreg;
`ifdef SERIAL_RX_PARITY_EN
  logic                   r_par_err;
`endif

  logic w_rxs;
  logic w_sample;

  // The pin synchronizer resets to idle-high, so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rxs    = r_sync[SYNC_STAGES-1];
  assign w_sample = (r_phase == LAST_PH);

  // Receive FSM and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_phase        <= '0;
      r_bitcnt       <= '0;
      r_shreg        <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_framing_err <= 1'b0;
      rx_overrun     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_err      <= 1'b0;
`endif
    end else begin
      // Error pulses last one clk, regardless of the baud8 rate.
      rx_framing_err <= 1'b0;
      rx_overrun     <= 1'b0;
      // A byte completing in this same cycle takes priority over the clear below.
      if (rx_ack) rx_valid <= 1'b0;

      if (baud8) begin
        case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_state <= S_START;
              r_phase <= '0;
            end
          end

          S_START: begin
            r_phase <= r_phase + PH_W'(1);
            if (r_phase == CHECK_PH) begin
              if (w_rxs) begin
                r_state <= S_IDLE;          // too short: a glitch
              end else begin
                r_state  <= S_DATA;
                r_phase  <= '0;
                r_bitcnt <= '0;
              end
            end
          end

          S_DATA: begin
            // When the phase wraps 7->0, the next bit's sample point starts counting.
            r_phase <= r_phase + PH_W'(1);
            if (w_sample) begin
              r_shreg  <= {w_rxs, r_shreg[7:1]};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end

`ifdef SERIAL_RX_PARITY_EN
          S_PARITY: begin
            r_phase <= r_phase + PH_W'(1);
            if (w_sample) begin
              r_par_err <= ^{r_shreg, w_rxs};   // even parity: total XOR must be 0
              r_state   <= S_STOP;
            end
          end
`endif

          S_STOP: begin
            r_phase <= r_phase + PH_W'(1);
            if (w_sample) begin
              if (!w_rxs) begin
                rx_framing_err <= 1'b1;
                r_state        <= S_BREAK;
              end else begin
                r_state <= S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                if (r_par_err) rx_framing_err <= 1'b1;
                else
`endif
                if (!rx_valid || rx_ack) begin
                  rx_data  <= r_shreg;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;         // keep the unread byte, drop the new one
                end
              end
            end
          end

          // Wait out a held-low line so that a break is not read as a stream of 0x00 bytes.
          S_BREAK: begin
            if (w_rxs) r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_8x.sv
// Directed testbench for serial_rx_8x. baud8 pulses every 8 clk (64 clk per bit).
module tb_serial_rx_8x;

  logic       clk;
  logic       rst;
  logic       baud8;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_framing_err;
  logic       rx_overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rise   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;
  logic [2:0] baud_cnt;

  serial_rx_8x dut (
    .clk           (clk),
    .rst           (rst),
    .baud8         (baud8),
    .rxd           (rxd),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_framing_err(rx_framing_err),
    .rx_overrun    (rx_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generate the baud8 strobe: it goes high on every eighth falling edge.
  initial begin
    baud8    = 1'b0;
    baud_cnt = 3'd0;
    forever begin
      @(negedge clk);
      baud_cnt = baud_cnt + 3'd1;
      baud8    = (baud_cnt == 3'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor. It samples just after each rising edge and checks pulse widths and rx_valid timing.
  always @(posedge clk) begin
    #1;
    if (rx_valid && !prev_valid) begin
      n_rise++;
      check("valid_rise_after_tick", 32'(baud8), 32'd1);
    end
    if (rx_framing_err) begin
      n_ferr++;
      check("ferr_pulse_width", 32'(prev_ferr), 32'd0);
    end
    if (rx_overrun) begin
      n_ovr++;
      check("ovr_pulse_width", 32'(prev_ovr), 32'd0);
    end
    prev_valid = rx_valid;
    prev_ferr  = rx_framing_err;
    prev_ovr   = rx_overrun;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line up on the falling edge just before a baud8 tick, so that bit timing is exact.
  task automatic align_start();
    @(posedge clk);
    while (baud8 !== 1'b1) @(posedge clk);
    wait_neg(8);
  endtask

  // Send one frame. If ack_c is set, rx_ack is raised for exactly the stop-sample cycle.
  // The start edge is placed at a tick, which puts the stop sample 40 clk into the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_c);
    align_start();
    rxd = 1'b0;
    wait_neg(64);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_neg(64);
    end
    rxd = stop;
    wait_neg(40);
    if (ack_c) rx_ack = 1'b1;
    wait_neg(1);
    rx_ack = 1'b0;
    wait_neg(23);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ack_clears_valid", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    rxd    = 1'b1;
    rx_ack = 1'b0;
    wait_neg(3);
    check("reset_data",  32'(rx_data), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_ferr",  32'(rx_framing_err), 32'd0);
    check("reset_ovr",   32'(rx_overrun), 32'd0);
    rst = 1'b0;
    wait_neg(100);

    // Basic receive of 0x55, followed by an acknowledge.
    send_frame(8'h55, 1'b1, 1'b0);
    check("b55_valid", 32'(rx_valid), 32'd1);
    check("b55_data",  32'(rx_data), 32'h55);
    check("b55_rises", 32'(n_rise), 32'd1);
    check("b55_noerr", 32'(n_ferr + n_ovr), 32'd0);
    do_ack();

    // Glitch rejection: a low lasting two ticks must not start a frame.
    align_start();
    rxd = 1'b0;
    wait_neg(16);
    rxd = 1'b1;
    wait_neg(200);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_rises", 32'(n_rise), 32'd1);
    check("glitch_ferr",  32'(n_ferr), 32'd0);

    // Back-to-back frames without an acknowledge: the second byte overruns.
    send_frame(8'hA3, 1'b1, 1'b0);
    check("a3_valid", 32'(rx_valid), 32'd1);
    check("a3_data",  32'(rx_data), 32'hA3);
    send_frame(8'h0F, 1'b1, 1'b0);
    check("ovr_count",   32'(n_ovr), 32'd1);
    check("ovr_data",    32'(rx_data), 32'hA3);
    check("ovr_valid",   32'(rx_valid), 32'd1);
    check("ovr_rises",   32'(n_rise), 32'd2);
    do_ack();

    // An acknowledge in the same cycle as completion replaces the byte without an overrun.
    send_frame(8'h12, 1'b1, 1'b0);
    check("b12_data", 32'(rx_data), 32'h12);
    send_frame(8'h34, 1'b1, 1'b1);
    check("coinc_data",  32'(rx_data), 32'h34);
    check("coinc_valid", 32'(rx_valid), 32'd1);
    check("coinc_ovr",   32'(n_ovr), 32'd1);
    check("coinc_rises", 32'(n_rise), 32'd3);
    do_ack();

    // A low stop bit gives a framing error. The line is then held low as a break.
    send_frame(8'h7E, 1'b0, 1'b0);
    check("frm_ferr",  32'(n_ferr), 32'd1);
    check("frm_valid", 32'(rx_valid), 32'd0);
    wait_neg(2000);
    check("brk_ferr",  32'(n_ferr), 32'd1);
    check("brk_rises", 32'(n_rise), 32'd3);
    check("brk_ovr",   32'(n_ovr), 32'd1);
    rxd = 1'b1;
    wait_neg(100);
    send_frame(8'h01, 1'b1, 1'b0);
    check("b01_data",  32'(rx_data), 32'h01);
    check("b01_valid", 32'(rx_valid), 32'd1);
    check("b01_ferr",  32'(n_ferr), 32'd1);

    // Assert reset asynchronously partway through 0xFF, after its 4th data bit.
    align_start();
    rxd = 1'b0;
    wait_neg(64);
    rxd = 1'b1;
    wait_neg(4 * 64 + 20);
    rst = 1'b1;
    #1;
    check("arst_data",  32'(rx_data), 32'h00);
    check("arst_valid", 32'(rx_valid), 32'd0);
    check("arst_ferr",  32'(rx_framing_err), 32'd0);
    check("arst_ovr",   32'(rx_overrun), 32'd0);
    wait_neg(4);
    rst = 1'b0;
    wait_neg(100);
    check("arst_quiet", 32'(rx_valid), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0);
    check("c3_data",  32'(rx_data), 32'hC3);
    check("c3_valid", 32'(rx_valid), 32'd1);
    check("c3_rises", 32'(n_rise), 32'd5);
    check("end_ferr", 32'(n_ferr), 32'd1);
    check("end_ovr",  32'(n_ovr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
